// File: rtl/regfile_wb.sv
// regfile_wb: 32-entry register file with the EX->MEM->WB destination
// pipeline, rs/rt operand forwarding and load-use stall detection.
// Register 0 is hardwired to zero: it is never written, never forwarded
// and never stalls.
`timescale 1ns/1ps
module regfile_wb #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pipe_en,
    input  logic [AW-1:0] ex_dst,
    input  logic          ex_wen,
    input  logic          ex_is_load,
    input  logic [DW-1:0] ex_result,
    input  logic [DW-1:0] mem_rdata,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    output logic          load_use_stall,
    output logic          wb_wen,
    output logic [AW-1:0] wb_dst
);

    localparam int NREG = 1 << AW;

    // MEM stage
    logic [AW-1:0] mem_dst_q, mem_dst_d;
    logic          mem_wen_q, mem_wen_d;
    logic          mem_is_load_q, mem_is_load_d;
    logic [DW-1:0] mem_alu_q, mem_alu_d;

    // WB stage
    logic [AW-1:0] wb_dst_q, wb_dst_d;
    logic          wb_wen_q, wb_wen_d;
    logic [DW-1:0] wb_data_q, wb_data_d;

    // Register array, flattened so per-entry generate blocks can drive slices
    logic [NREG*DW-1:0] rf_flat;

    logic [DW-1:0] mem_data;
    logic          ex_fwd;
    logic          mem_fwd;
    logic          wb_fwd;
    logic          commit;

    // Result a MEM-stage instruction will hand to WB
    assign mem_data = mem_is_load_q ? mem_rdata : mem_alu_q;

    // A stage "writes" only when enabled and not targeting r0; a load in EX
    // has no data yet, so it never forwards from EX.
    assign ex_fwd  = ex_wen & (ex_dst != '0) & ~ex_is_load;
    assign mem_fwd = mem_wen_q & (mem_dst_q != '0);
    assign wb_fwd  = wb_wen_q & (wb_dst_q != '0);
    assign commit  = pipe_en & wb_fwd;

    // Stage advance: everything holds while pipe_en is low
    always_comb begin
        mem_dst_d     = mem_dst_q;
        mem_wen_d     = mem_wen_q;
        mem_is_load_d = mem_is_load_q;
        mem_alu_d     = mem_alu_q;
        wb_dst_d      = wb_dst_q;
        wb_wen_d      = wb_wen_q;
        wb_data_d     = wb_data_q;
        if (pipe_en) begin
            mem_dst_d     = ex_dst;
            mem_wen_d     = ex_wen;
            mem_is_load_d = ex_is_load;
            mem_alu_d     = ex_result;
            wb_dst_d      = mem_dst_q;
            wb_wen_d      = mem_wen_q;
            wb_data_d     = mem_data;
        end
    end

    // Stage registers; reset drops any in-flight write
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_dst_q     <= '0;
            mem_wen_q     <= 1'b0;
            mem_is_load_q <= 1'b0;
            mem_alu_q     <= '0;
            wb_dst_q      <= '0;
            wb_wen_q      <= 1'b0;
            wb_data_q     <= '0;
        end else begin
            mem_dst_q     <= mem_dst_d;
            mem_wen_q     <= mem_wen_d;
            mem_is_load_q <= mem_is_load_d;
            mem_alu_q     <= mem_alu_d;
            wb_dst_q      <= wb_dst_d;
            wb_wen_q      <= wb_wen_d;
            wb_data_q     <= wb_data_d;
        end
    end

    // One register per array entry; reset must clear every entry, so the
    // array is built from flops rather than a RAM.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : gen_reg
            logic [DW-1:0] entry_q, entry_d;

            // Entry update from the WB stage commit
            always_comb begin
                entry_d = entry_q;
                if (commit && (wb_dst_q == AW'(gi))) begin
                    entry_d = wb_data_q;
                end
            end

            // Entry storage
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_q <= '0;
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign rf_flat[gi*DW +: DW] = entry_q;
        end
    endgenerate

    // Read ports: 0 = rs, 1 = rt
    logic [AW-1:0] rd_idx [2];
    assign rd_idx[0] = id_rs;
    assign rd_idx[1] = id_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_rd
            logic [DW-1:0] val;

            // Operand source priority: r0, EX, MEM, WB, then the array
            always_comb begin
                val = rf_flat[int'(rd_idx[gi])*DW +: DW];
                if (rd_idx[gi] == '0) begin
                    val = '0;
                end else if (ex_fwd && (ex_dst == rd_idx[gi])) begin
                    val = ex_result;
                end else if (mem_fwd && (mem_dst_q == rd_idx[gi])) begin
                    val = mem_data;
                end else if (wb_fwd && (wb_dst_q == rd_idx[gi])) begin
                    val = wb_data_q;
                end
            end
        end
    endgenerate

    assign rs_data = gen_rd[0].val;
    assign rt_data = gen_rd[1].val;

    // A load still in EX cannot supply data to the instruction in ID
    assign load_use_stall = ex_wen & ex_is_load & (ex_dst != '0) &
                            ((ex_dst == id_rs) | (ex_dst == id_rt));

    assign wb_wen = wb_wen_q;
    assign wb_dst = wb_dst_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb: the driver pushes the expected outputs for
// each cycle; the monitor pops and compares on the falling edge.
`timescale 1ns/1ps
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_en;
    logic [4:0]  ex_dst;
    logic        ex_wen;
    logic        ex_is_load;
    logic [31:0] ex_result;
    logic [31:0] mem_rdata;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        load_use_stall;
    logic        wb_wen;
    logic [4:0]  wb_dst;

    always #5 clk = ~clk;

    regfile_wb #(.DW(32), .AW(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .pipe_en        (pipe_en),
        .ex_dst         (ex_dst),
        .ex_wen         (ex_wen),
        .ex_is_load     (ex_is_load),
        .ex_result      (ex_result),
        .mem_rdata      (mem_rdata),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .load_use_stall (load_use_stall),
        .wb_wen         (wb_wen),
        .wb_dst         (wb_dst)
    );

    typedef struct {
        string       nm;
        bit          crs;
        logic [31:0] ers;
        bit          crt;
        logic [31:0] ert;
        bit          cst;
        logic        est;
        bit          cwb;
        logic        ewb;
        logic [4:0]  ewd;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) begin
            n_pass++;
            $display("check %s: got %h", nm, got);
        end else begin
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Monitor: compare the DUT against the oldest pending expectation
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.crs) check({e.nm, ".rs"}, rs_data, e.ers);
            if (e.crt) check({e.nm, ".rt"}, rt_data, e.ert);
            if (e.cst) check({e.nm, ".stall"}, {31'd0, load_use_stall}, {31'd0, e.est});
            if (e.cwb) begin
                check({e.nm, ".wb_wen"}, {31'd0, wb_wen}, {31'd0, e.ewb});
                check({e.nm, ".wb_dst"}, {27'd0, wb_dst}, {27'd0, e.ewd});
            end
        end
    end

    task automatic expect_(input string nm,
                           input bit crs, input logic [31:0] ers,
                           input bit crt, input logic [31:0] ert,
                           input bit cst, input logic est,
                           input bit cwb, input logic ewb, input logic [4:0] ewd);
        exp_t e;
        e.nm = nm; e.crs = crs; e.ers = ers; e.crt = crt; e.ert = ert;
        e.cst = cst; e.est = est; e.cwb = cwb; e.ewb = ewb; e.ewd = ewd;
        sb.push_back(e);
    endtask

    task automatic ex(input logic wen, input logic ld, input logic [4:0] dst, input logic [31:0] res);
        ex_wen = wen; ex_is_load = ld; ex_dst = dst; ex_result = res;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; pipe_en = 1'b1; mem_rdata = '0; id_rs = '0; id_rt = '0;
        ex(0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;

        // Reset then read
        id_rs = 5; id_rt = 31;
        expect_("reset", 1, 0, 1, 0, 1, 0, 1, 0, 0); tick();

        // Write r3 and follow it to commit
        id_rs = 3; id_rt = 0;
        ex(1, 0, 3, 32'h1234);
        expect_("wr_c0", 1, 32'h1234, 1, 0, 1, 0, 1, 0, 0); tick();
        ex(0, 0, 0, 0);
        expect_("wr_c1", 1, 32'h1234, 0, 0, 0, 0, 1, 0, 0); tick();
        expect_("wr_c2", 1, 32'h1234, 0, 0, 0, 0, 1, 1, 3); tick();
        expect_("wr_c3", 1, 32'h1234, 0, 0, 0, 0, 1, 0, 0); tick();

        // Back-to-back writes to r7: youngest wins
        id_rs = 0; id_rt = 7;
        ex(1, 0, 7, 32'hA);
        expect_("pri_c0", 0, 0, 1, 32'hA, 0, 0, 0, 0, 0); tick();
        ex(1, 0, 7, 32'hB);
        expect_("pri_c1", 0, 0, 1, 32'hB, 0, 0, 0, 0, 0); tick();
        ex(1, 0, 7, 32'hC);
        expect_("pri_c2", 0, 0, 1, 32'hC, 0, 0, 1, 1, 7); tick();
        ex(0, 0, 0, 0); id_rs = 7;
        expect_("pri_c3", 1, 32'hC, 1, 32'hC, 0, 0, 1, 1, 7); tick();
        expect_("pri_c4", 0, 0, 1, 32'hC, 0, 0, 1, 1, 7); tick();
        expect_("pri_c5", 1, 32'hC, 1, 32'hC, 0, 0, 1, 0, 0); tick();

        // Load-use on rs, then on rt
        id_rs = 9; id_rt = 0;
        ex(1, 1, 9, 32'h5555);
        expect_("lu_c0", 1, 0, 0, 0, 1, 1, 0, 0, 0); tick();
        ex(0, 0, 0, 0); mem_rdata = 32'hDEAD;
        expect_("lu_c1", 1, 32'hDEAD, 0, 0, 1, 0, 0, 0, 0); tick();
        mem_rdata = 0;
        expect_("lu_c2", 1, 32'hDEAD, 0, 0, 1, 0, 1, 1, 9); tick();
        id_rs = 0; id_rt = 9;
        ex(1, 1, 9, 0);
        expect_("lu_c3", 0, 0, 1, 32'hDEAD, 1, 1, 0, 0, 0); tick();
        ex(0, 0, 0, 0); mem_rdata = 32'hBEEF;
        expect_("lu_c4", 0, 0, 1, 32'hBEEF, 1, 0, 0, 0, 0); tick();
        mem_rdata = 0;
        expect_("lu_c5", 0, 0, 1, 32'hBEEF, 0, 0, 1, 1, 9); tick();
        expect_("lu_c6", 0, 0, 1, 32'hBEEF, 0, 0, 0, 0, 0); tick();
        id_rs = 9; id_rt = 0;
        ex(0, 1, 9, 0);
        expect_("lu_nowen", 1, 32'hBEEF, 0, 0, 1, 0, 0, 0, 0); tick();
        ex(0, 0, 0, 0);

        // Register 0 is never written, forwarded or stalled on
        id_rs = 0; id_rt = 0;
        ex(1, 0, 0, 32'hFFFF_FFFF);
        expect_("r0_c0", 1, 0, 1, 0, 1, 0, 0, 0, 0); tick();
        ex(1, 1, 0, 32'hFFFF_FFFF);
        expect_("r0_c1", 1, 0, 1, 0, 1, 0, 0, 0, 0); tick();
        ex(0, 0, 0, 0); id_rt = 3;
        expect_("r0_c2", 1, 0, 1, 32'h1234, 0, 0, 1, 1, 0); tick();
        expect_("r0_c3", 1, 0, 0, 0, 0, 0, 1, 1, 0); tick();
        expect_("r0_c4", 1, 0, 0, 0, 0, 0, 1, 0, 0); tick();

        // Freeze with r4 in MEM, release, then reset before the commit edge
        id_rs = 4; id_rt = 0;
        ex(1, 0, 4, 32'h44);
        expect_("frz_c0", 1, 32'h44, 0, 0, 0, 0, 0, 0, 0); tick();
        ex(0, 0, 0, 0); pipe_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_($sformatf("frz_hold%0d", i), 1, 32'h44, 0, 0, 0, 0, 1, 0, 0);
            tick();
        end
        pipe_en = 1'b1;
        expect_("frz_rel", 1, 32'h44, 0, 0, 0, 0, 1, 0, 0); tick();
        rst = 1'b1;
        expect_("frz_wb", 1, 32'h44, 0, 0, 0, 0, 1, 1, 4); tick();
        rst = 1'b0; id_rt = 3;
        expect_("rst_c0", 1, 0, 1, 0, 1, 0, 1, 0, 0); tick();
        id_rs = 9; id_rt = 7;
        expect_("rst_c1", 1, 0, 1, 0, 1, 0, 1, 0, 0); tick();

        tick();
        n_total++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
